// File: rtl/dmem_sequencer.sv
// Data-memory access sequencer: CPU loads/stores (sub-word stores via read-modify-write)
// and debug word reads onto a single-port synchronous RAM.
//
// state        | meaning
// -------------+----------------------------------------------------------
// ST_IDLE      | accept CPU access (priority) or a debug read
// ST_LOAD_WAIT | RAM data returning; extract lane, extend, release stall
// ST_RMW_WRITE | merge store lane into the read word and write it back
// ST_DBG_WAIT  | RAM data returning for debug; capture into dbg_rdata_o
module dmem_sequencer #(
   parameter int NB_DATA     = 32,
   parameter int NB_ADDR     = 7,
   parameter int NB_MEM_CTRL = 6
) (
   input  logic                   clock_i,
   input  logic                   reset_i,
   input  logic [NB_ADDR+1:0]     cpu_addr_i,
   input  logic [NB_MEM_CTRL-1:0] cpu_ctrl_i,
   input  logic [NB_DATA-1:0]     cpu_wdata_i,
   output logic [NB_DATA-1:0]     cpu_rdata_o,
   output logic                   cpu_stall_o,
   input  logic                   dbg_req_i,
   input  logic [NB_ADDR-1:0]     dbg_addr_i,
   output logic [NB_DATA-1:0]     dbg_rdata_o,
   output logic                   dbg_valid_o,
   output logic [NB_ADDR-1:0]     mem_addr_o,
   output logic [NB_DATA-1:0]     mem_wdata_o,
   output logic                   mem_we_o,
   output logic                   mem_re_o,
   input  logic [NB_DATA-1:0]     mem_rdata_i
);

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_LOAD_WAIT = 2'd1;
   localparam logic [1:0] ST_RMW_WRITE = 2'd2;
   localparam logic [1:0] ST_DBG_WAIT  = 2'd3;

   localparam logic [2:0] SIZE_BYTE = 3'b001;
   localparam logic [2:0] SIZE_HALF = 3'b010;
   localparam logic [2:0] SIZE_WORD = 3'b100;

   logic [1:0]         state;
   logic [1:0]         state_next;
   logic [NB_ADDR-1:0] lat_word;
   logic [1:0]         lat_lane;
   logic [2:0]         lat_size;
   logic               lat_zext;
   logic               lat_load;

   logic               cpu_rd;
   logic               cpu_wr;
   logic               cpu_req;
   logic [2:0]         cpu_size;
   logic [NB_DATA-1:0] load_data;
   logic [NB_DATA-1:0] merge_data;
   logic [7:0]         lane_byte;
   logic [15:0]        lane_half;

   // A read with the write bit also set is treated purely as a read.
   assign cpu_rd   = cpu_ctrl_i[5];
   assign cpu_wr   = cpu_ctrl_i[4] & ~cpu_ctrl_i[5];
   assign cpu_req  = cpu_ctrl_i[5] | cpu_ctrl_i[4];
   assign cpu_size = cpu_ctrl_i[3:1];

   always_comb begin
      lane_byte = mem_rdata_i[{lat_lane, 3'b000} +: 8];
      lane_half = mem_rdata_i[{lat_lane[1], 4'b0000} +: 16];
      case (lat_size)
         SIZE_BYTE: load_data = {{(NB_DATA-8){~lat_zext & lane_byte[7]}}, lane_byte};
         SIZE_HALF: load_data = {{(NB_DATA-16){~lat_zext & lane_half[15]}}, lane_half};
         SIZE_WORD: load_data = mem_rdata_i;
         default:   load_data = '0;
      endcase
   end

   always_comb begin
      merge_data = mem_rdata_i;
      if (lat_size == SIZE_BYTE) begin
         merge_data[{lat_lane, 3'b000} +: 8] = cpu_wdata_i[7:0];
      end else if (lat_size == SIZE_HALF) begin
         merge_data[{lat_lane[1], 4'b0000} +: 16] = cpu_wdata_i[15:0];
      end
   end

   always_comb begin
      state_next  = state;
      mem_addr_o  = cpu_addr_i[NB_ADDR+1:2];
      mem_wdata_o = cpu_wdata_i;
      mem_we_o    = 1'b0;
      mem_re_o    = 1'b0;
      cpu_stall_o = 1'b0;
      cpu_rdata_o = '0;
      lat_load    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (cpu_rd) begin
               mem_re_o    = 1'b1;
               cpu_stall_o = 1'b1;
               lat_load    = 1'b1;
               state_next  = ST_LOAD_WAIT;
            end else if (cpu_wr) begin
               if (cpu_size == SIZE_WORD) begin
                  mem_we_o = 1'b1;
               end else if (cpu_size == SIZE_BYTE || cpu_size == SIZE_HALF) begin
                  mem_re_o    = 1'b1;
                  cpu_stall_o = 1'b1;
                  lat_load    = 1'b1;
                  state_next  = ST_RMW_WRITE;
               end
            end else if (!cpu_req && dbg_req_i && !dbg_valid_o) begin
               mem_addr_o = dbg_addr_i;
               mem_re_o   = 1'b1;
               state_next = ST_DBG_WAIT;
            end
         end
         ST_LOAD_WAIT: begin
            mem_addr_o  = lat_word;
            cpu_rdata_o = load_data;
            state_next  = ST_IDLE;
         end
         ST_RMW_WRITE: begin
            mem_addr_o  = lat_word;
            mem_wdata_o = merge_data;
            mem_we_o    = 1'b1;
            state_next  = ST_IDLE;
         end
         default: begin
            // CPU arriving during the debug return slot waits one cycle.
            mem_addr_o  = dbg_addr_i;
            cpu_stall_o = cpu_req;
            state_next  = ST_IDLE;
         end
      endcase
      if (reset_i) begin
         mem_we_o    = 1'b0;
         mem_re_o    = 1'b0;
         cpu_stall_o = 1'b0;
         cpu_rdata_o = '0;
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state       <= ST_IDLE;
         dbg_rdata_o <= '0;
         dbg_valid_o <= 1'b0;
         lat_word    <= '0;
         lat_lane    <= '0;
         lat_size    <= '0;
         lat_zext    <= 1'b0;
      end else begin
         state       <= state_next;
         dbg_valid_o <= (state == ST_DBG_WAIT);
         if (state == ST_DBG_WAIT) begin
            dbg_rdata_o <= mem_rdata_i;
         end
         if (lat_load) begin
            lat_word <= cpu_addr_i[NB_ADDR+1:2];
            lat_lane <= cpu_addr_i[1:0];
            lat_size <= cpu_size;
            lat_zext <= cpu_ctrl_i[0];
         end
      end
   end

endmodule

// File: tb/tb_dmem_sequencer.sv
// Bench for dmem_sequencer: directed scenarios plus random CPU traffic checked
// against a word-array reference model of loads/stores.
module tb_dmem_sequencer;
   localparam int NB_DATA     = 32;
   localparam int NB_ADDR     = 7;
   localparam int NB_MEM_CTRL = 6;

   logic                   clock_i = 1'b0;
   logic                   reset_i;
   logic [NB_ADDR+1:0]     cpu_addr_i;
   logic [NB_MEM_CTRL-1:0] cpu_ctrl_i;
   logic [NB_DATA-1:0]     cpu_wdata_i;
   logic [NB_DATA-1:0]     cpu_rdata_o;
   logic                   cpu_stall_o;
   logic                   dbg_req_i;
   logic [NB_ADDR-1:0]     dbg_addr_i;
   logic [NB_DATA-1:0]     dbg_rdata_o;
   logic                   dbg_valid_o;
   logic [NB_ADDR-1:0]     mem_addr_o;
   logic [NB_DATA-1:0]     mem_wdata_o;
   logic                   mem_we_o;
   logic                   mem_re_o;
   logic [NB_DATA-1:0]     mem_rdata_i;

   dmem_sequencer #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR), .NB_MEM_CTRL(NB_MEM_CTRL)) dut (
      .clock_i(clock_i), .reset_i(reset_i),
      .cpu_addr_i(cpu_addr_i), .cpu_ctrl_i(cpu_ctrl_i), .cpu_wdata_i(cpu_wdata_i),
      .cpu_rdata_o(cpu_rdata_o), .cpu_stall_o(cpu_stall_o),
      .dbg_req_i(dbg_req_i), .dbg_addr_i(dbg_addr_i),
      .dbg_rdata_o(dbg_rdata_o), .dbg_valid_o(dbg_valid_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_we_o(mem_we_o), .mem_re_o(mem_re_o), .mem_rdata_i(mem_rdata_i)
   );

   always #5 clock_i = ~clock_i;

   // Synchronous single-port RAM with a backdoor write port for preloading.
   logic [31:0] ram [128];
   logic        bd_we = 1'b0;
   logic [6:0]  bd_addr = '0;
   logic [31:0] bd_data = '0;
   always @(posedge clock_i) begin
      if (bd_we) ram[bd_addr] <= bd_data;
      else if (mem_we_o) ram[mem_addr_o] <= mem_wdata_o;
      if (mem_re_o) mem_rdata_i <= ram[mem_addr_o];
   end

   int dbg_pulses = 0;
   always @(negedge clock_i) if (dbg_valid_o) dbg_pulses++;

   logic [31:0] ref_mem [128];
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic poke(input logic [6:0] a, input logic [31:0] d);
      bd_addr = a; bd_data = d; bd_we = 1'b1;
      @(posedge clock_i); #1;
      bd_we = 1'b0;
      ref_mem[a] = d;
   endtask

   // One CPU access: hold inputs until stall drops (bounded), report last cycle.
   task automatic access(input logic [8:0] addr, input logic [5:0] ctrl, input logic [31:0] wdata,
                         output int stalls, output logic [31:0] rdata, output logic we_last);
      logic st;
      cpu_addr_i = addr; cpu_ctrl_i = ctrl; cpu_wdata_i = wdata;
      stalls = 0; rdata = '0; we_last = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clock_i);
         rdata = cpu_rdata_o; we_last = mem_we_o; st = cpu_stall_o;
         @(posedge clock_i); #1;
         if (!st) break;
         stalls++;
      end
      cpu_ctrl_i = '0;
   endtask

   function automatic logic [31:0] ref_load(input logic [8:0] addr, input logic [5:0] ctrl);
      logic [31:0] w, v;
      int lane;
      w = ref_mem[addr[8:2]];
      lane = int'(addr[1:0]);
      case (ctrl[3:1])
         3'b001: begin
            v = (w >> (8 * lane)) & 32'h0000_00FF;
            if (!ctrl[0] && v[7]) v = v | 32'hFFFF_FF00;
         end
         3'b010: begin
            v = (w >> (16 * (lane / 2))) & 32'h0000_FFFF;
            if (!ctrl[0] && v[15]) v = v | 32'hFFFF_0000;
         end
         3'b100:  v = w;
         default: v = 32'h0;
      endcase
      return v;
   endfunction

   // Expected behaviour of one access; updates the reference memory.
   task automatic ref_op(input logic [8:0] addr, input logic [5:0] ctrl, input logic [31:0] wdata,
                         output int e_st, output logic [31:0] e_rd, output logic e_we);
      int lane, sh;
      logic [31:0] m;
      logic [6:0] wi;
      wi = addr[8:2];
      lane = int'(addr[1:0]);
      e_st = 0; e_rd = 32'h0; e_we = 1'b0;
      if (ctrl[5]) begin
         e_st = 1;
         e_rd = ref_load(addr, ctrl);
      end else if (ctrl[4]) begin
         case (ctrl[3:1])
            3'b001: begin
               e_st = 1; e_we = 1'b1; sh = 8 * lane; m = 32'hFF << sh;
               ref_mem[wi] = (ref_mem[wi] & ~m) | ((wdata & 32'hFF) << sh);
            end
            3'b010: begin
               e_st = 1; e_we = 1'b1; sh = 16 * (lane / 2); m = 32'hFFFF << sh;
               ref_mem[wi] = (ref_mem[wi] & ~m) | ((wdata & 32'hFFFF) << sh);
            end
            3'b100: begin
               e_we = 1'b1; ref_mem[wi] = wdata;
            end
            default: ;
         endcase
      end
   endtask

   int          stalls, e_st, n, p0;
   logic [31:0] rd, e_rd, wd;
   logic        we, e_we, seen;
   logic [8:0]  ra;
   logic [5:0]  rc;
   logic [2:0]  sz;
   logic [6:0]  da;

   initial begin
      reset_i = 1'b1; dbg_req_i = 1'b1; dbg_addr_i = 7'd7;
      cpu_addr_i = 9'h016; cpu_ctrl_i = 6'b100010; cpu_wdata_i = '0;
      @(posedge clock_i); #1;
      for (int i = 0; i < 128; i++) poke(7'(i), $urandom);
      @(negedge clock_i);
      check("rst_we", 32'(mem_we_o), 32'h0);
      check("rst_re", 32'(mem_re_o), 32'h0);
      check("rst_stall", 32'(cpu_stall_o), 32'h0);
      check("rst_rdata", cpu_rdata_o, 32'h0);
      check("rst_dbg_valid", 32'(dbg_valid_o), 32'h0);
      check("rst_dbg_rdata", dbg_rdata_o, 32'h0);
      @(posedge clock_i); #1;
      reset_i = 1'b0; dbg_req_i = 1'b0; cpu_ctrl_i = '0;
      @(posedge clock_i); #1;

      // Lane extraction of loads
      poke(7'd5, 32'h12AB_80CD);
      access(9'h016, 6'b100010, 32'h0, stalls, rd, we);
      check("ld_sb_stall", 32'(stalls), 32'd1);
      check("ld_sb_data", rd, 32'hFFFF_FFAB);
      access(9'h016, 6'b100101, 32'h0, stalls, rd, we);
      check("ld_zh_stall", 32'(stalls), 32'd1);
      check("ld_zh_data", rd, 32'h0000_12AB);

      // Byte RMW then zero-stall word store
      poke(7'd3, 32'h1122_3344);
      access(9'h00D, 6'b010010, 32'hFFFF_FFAA, stalls, rd, we);
      check("sb_stall", 32'(stalls), 32'd1);
      check("sb_we_2nd", 32'(we), 32'h1);
      check("sb_ram", ram[3], 32'h1122_AA44);
      access(9'h00C, 6'b011000, 32'hDEAD_BEEF, stalls, rd, we);
      check("sw_stall", 32'(stalls), 32'd0);
      check("sw_we", 32'(we), 32'h1);
      check("sw_ram", ram[3], 32'hDEAD_BEEF);
      ref_mem[3] = 32'hDEAD_BEEF;

      // Debug held off while CPU loads run back-to-back
      poke(7'd7, 32'hCAFE_0001);
      dbg_addr_i = 7'd7; dbg_req_i = 1'b1; p0 = dbg_pulses;
      for (int k = 0; k < 3; k++) begin
         ra = 9'(4 * (k + 1));
         access(ra, 6'b101001, 32'h0, stalls, rd, we);
         check("arb_ld_stall", 32'(stalls), 32'd1);
         check("arb_ld_data", rd, ref_mem[ra[8:2]]);
      end
      check("arb_no_dbg", 32'(dbg_pulses - p0), 32'd0);
      @(negedge clock_i);
      check("dbg_accept_re", 32'(mem_re_o), 32'h1);
      check("dbg_accept_addr", 32'(mem_addr_o), 32'd7);
      @(posedge clock_i); #1;
      n = 1; seen = 1'b0;
      while (!seen && n < 6) begin
         @(negedge clock_i);
         if (dbg_valid_o) seen = 1'b1;
         else begin
            @(posedge clock_i); #1;
            n++;
         end
      end
      check("dbg_latency", 32'(n), 32'd2);
      check("dbg_rdata", dbg_rdata_o, 32'hCAFE_0001);
      dbg_req_i = 1'b0;
      @(posedge clock_i); #1;
      @(negedge clock_i);
      check("dbg_valid_pulse", 32'(dbg_valid_o), 32'h0);
      check("dbg_rdata_hold", dbg_rdata_o, 32'hCAFE_0001);
      @(posedge clock_i); #1;

      // Reset during the write-back cycle of a half store
      poke(7'd9, 32'h0BAD_F00D);
      cpu_addr_i = 9'h026; cpu_ctrl_i = 6'b010100; cpu_wdata_i = 32'h0000_5555;
      @(negedge clock_i);
      check("rmw_rst_stall0", 32'(cpu_stall_o), 32'h1);
      @(posedge clock_i); #1;
      reset_i = 1'b1;
      @(negedge clock_i);
      check("rmw_rst_we", 32'(mem_we_o), 32'h0);
      check("rmw_rst_re", 32'(mem_re_o), 32'h0);
      check("rmw_rst_stall", 32'(cpu_stall_o), 32'h0);
      check("rmw_rst_rdata", cpu_rdata_o, 32'h0);
      @(posedge clock_i); #1;
      reset_i = 1'b0; cpu_ctrl_i = '0;
      @(negedge clock_i);
      check("rmw_rst_ram", ram[9], 32'h0BAD_F00D);
      check("rmw_rst_dbgv", 32'(dbg_valid_o), 32'h0);
      @(posedge clock_i); #1;
      access(9'h024, 6'b101001, 32'h0, stalls, rd, we);
      check("post_rst_stall", 32'(stalls), 32'd1);
      check("post_rst_data", rd, 32'h0BAD_F00D);

      // Illegal sizes
      access(9'h020, 6'b110000, 32'h1234_5678, stalls, rd, we);
      check("ill_rw_stall", 32'(stalls), 32'd1);
      check("ill_rw_data", rd, 32'h0);
      check("ill_rw_we", 32'(we), 32'h0);
      access(9'h020, 6'b010110, 32'h1234_5678, stalls, rd, we);
      check("ill_w_stall", 32'(stalls), 32'd0);
      check("ill_w_we", 32'(we), 32'h0);
      check("ill_ram", ram[8], ref_mem[8]);

      // Random CPU traffic against the reference model
      for (int t = 0; t < 200; t++) begin
         ra = 9'($urandom_range(0, 511));
         case ($urandom_range(0, 3))
            0: sz = 3'b001;
            1: sz = 3'b010;
            2: sz = 3'b100;
            default: sz = 3'($urandom_range(0, 7));
         endcase
         case ($urandom_range(0, 9))
            0, 1, 2, 3: rc = {2'b10, sz, 1'($urandom_range(0, 1))};
            4, 5, 6, 7: rc = {2'b01, sz, 1'($urandom_range(0, 1))};
            8:          rc = 6'b000000;
            default:    rc = {2'b11, sz, 1'($urandom_range(0, 1))};
         endcase
         wd = $urandom;
         ref_op(ra, rc, wd, e_st, e_rd, e_we);
         access(ra, rc, wd, stalls, rd, we);
         check("rnd_stall", 32'(stalls), 32'(e_st));
         check("rnd_we", 32'(we), 32'(e_we));
         if (rc[5]) check("rnd_rdata", rd, e_rd);
      end
      for (int i = 0; i < 128; i++) check("rnd_ram", ram[i], ref_mem[i]);

      // Final debug read of a random word
      da = 7'($urandom_range(0, 127));
      dbg_addr_i = da; dbg_req_i = 1'b1;
      n = 0; seen = 1'b0;
      while (!seen && n < 8) begin
         @(negedge clock_i);
         if (dbg_valid_o) seen = 1'b1;
         else begin
            @(posedge clock_i); #1;
            n++;
         end
      end
      check("dbg_rnd_seen", 32'(seen), 32'h1);
      check("dbg_rnd_data", dbg_rdata_o, ref_mem[da]);
      dbg_req_i = 1'b0;
      @(posedge clock_i); #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
